// File: rtl/edge_accum_pkg.sv
// Shared defaults, FSM state encoding and width helper for the edge accumulator.
package edge_accum_pkg;
    localparam int DEF_CHUNK_W = 128;
    localparam int DEF_CHUNKS  = 32;
    localparam int DEF_RD_W    = 32;
    localparam int CNT_W       = 16;

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/edge_accum_rdmux.sv
// Combinational word select from the result vector; the parent registers the output.
module edge_accum_rdmux
    import edge_accum_pkg::*;
#(
    parameter int FRAME_W = DEF_CHUNK_W * DEF_CHUNKS,
    parameter int RD_W    = DEF_RD_W,
    parameter int RA_W    = clog2(FRAME_W / RD_W)
) (
    input  logic [FRAME_W-1:0] result,
    input  logic [RA_W-1:0]    addr,
    output logic [RD_W-1:0]    word
);
    assign word = result[addr*RD_W +: RD_W];
endmodule

// File: rtl/edge_accum_v2_0.sv
// Assembles CHUNKS edge-mask chunks into a frame, then commits it (overwrite or OR) into a
// readable result; one bubble cycle per frame, registered read port with latency 1.
module edge_accum_v2_0
    import edge_accum_pkg::*;
#(
    parameter int CHUNK_W   = DEF_CHUNK_W,
    parameter int CHUNKS    = DEF_CHUNKS,
    parameter int RD_W      = DEF_RD_W,
    localparam int FRAME_W  = CHUNK_W * CHUNKS,
    localparam int NWORDS   = FRAME_W / RD_W,
    localparam int RA_W     = clog2(NWORDS),
    localparam int CI_W     = clog2(CHUNKS)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK_W-1:0] in_data,
    input  logic               mode_or,
    input  logic               clr,
    output logic [CI_W-1:0]    chunk_idx,
    output logic               frame_done,
    output logic [CNT_W-1:0]   frame_cnt,
    input  logic [RA_W-1:0]    rd_addr,
    output logic [RD_W-1:0]    rd_data
);
    state_t             state;
    logic [FRAME_W-1:0] frame_buf;
    logic [FRAME_W-1:0] result;
    logic [RD_W-1:0]    rd_word;

    assign in_ready = (state == FILL) && !clr && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= FILL;
            frame_buf  <= '0;
            result     <= '0;
            chunk_idx  <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            if (clr) begin
                state     <= FILL;
                frame_buf <= '0;
                result    <= '0;
                chunk_idx <= '0;
            end else begin
                case (state)
                    FILL: begin
                        if (in_valid) begin
                            // Earliest chunk ends up in the most significant slot.
                            frame_buf <= {frame_buf[FRAME_W-CHUNK_W-1:0], in_data};
                            chunk_idx <= chunk_idx + CI_W'(1);
                            if (chunk_idx == CI_W'(CHUNKS - 1)) state <= COMMIT;
                        end
                    end
                    COMMIT: begin
                        result     <= mode_or ? (result | frame_buf) : frame_buf;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + CNT_W'(1);
                        state      <= FILL;
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

    edge_accum_rdmux #(
        .FRAME_W (FRAME_W),
        .RD_W    (RD_W),
        .RA_W    (RA_W)
    ) u_rdmux (
        .result (result),
        .addr   (rd_addr),
        .word   (rd_word)
    );

    // Samples the pre-update result, so a read in the commit cycle sees the old frame.
    always_ff @(posedge CLK) begin
        if (RST) rd_data <= '0;
        else     rd_data <= rd_word;
    end
endmodule

// File: tb/tb_edge_accum_v2_0.sv
// Directed bench for edge_accum_v2_0 with a frame-level reference model and literal anchors.
module tb_edge_accum_v2_0;
    localparam int CHUNK_W = 128;
    localparam int CHUNKS  = 32;
    localparam int RD_W    = 32;
    localparam int FRAME_W = CHUNK_W * CHUNKS;
    localparam int RA_W    = 7;
    localparam int CI_W    = 5;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [CHUNK_W-1:0] in_data = '0;
    logic               mode_or = 1'b0;
    logic               clr = 1'b0;
    logic [CI_W-1:0]    chunk_idx;
    logic               frame_done;
    logic [15:0]        frame_cnt;
    logic [RA_W-1:0]    rd_addr = '0;
    logic [RD_W-1:0]    rd_data;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    edge_accum_v2_0 #(.CHUNK_W(CHUNK_W), .CHUNKS(CHUNKS), .RD_W(RD_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mode_or    (mode_or),
        .clr        (clr),
        .chunk_idx  (chunk_idx),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level model: chunks collected in an array, placed into the result at commit.
    int                 m_k = 0;
    bit                 m_commit = 1'b0;
    logic [CHUNK_W-1:0] m_chunks [CHUNKS];
    logic [FRAME_W-1:0] m_result = '0;
    logic [FRAME_W-1:0] m_frame;
    bit                 m_done = 1'b0;
    logic [15:0]        m_cnt = '0;
    logic [RD_W-1:0]    m_rd = '0;

    always @(posedge CLK) begin
        if (RST) begin
            m_k = 0; m_commit = 0; m_result = '0; m_done = 0; m_cnt = '0; m_rd = '0;
        end else begin
            m_rd   = m_result[int'(rd_addr)*RD_W +: RD_W];
            m_done = 0;
            if (clr) begin
                m_k = 0; m_commit = 0; m_result = '0;
            end else if (m_commit) begin
                for (int k = 0; k < CHUNKS; k++)
                    m_frame[(CHUNKS-1-k)*CHUNK_W +: CHUNK_W] = m_chunks[k];
                m_result = mode_or ? (m_result | m_frame) : m_frame;
                m_done   = 1;
                m_cnt    = m_cnt + 16'd1;
                m_commit = 0;
            end else if (in_valid) begin
                m_chunks[m_k] = in_data;
                if (m_k == CHUNKS - 1) begin m_k = 0; m_commit = 1; end
                else m_k++;
            end
        end
    end

    always @(posedge CLK) begin
        #3;
        if (chk_en) begin
            chk("in_ready",   64'(in_ready),   64'(!m_commit && !clr && !RST));
            chk("chunk_idx",  64'(chunk_idx),  64'(m_k));
            chk("frame_done", 64'(frame_done), 64'(m_done));
            chk("frame_cnt",  64'(frame_cnt),  64'(m_cnt));
            chk("rd_data",    64'(rd_data),    64'(m_rd));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [CHUNK_W-1:0] c0, input bit ramp);
        for (int k = 0; k < CHUNKS; k++) begin
            in_valid = 1'b1;
            in_data  = (k == 0) ? c0 : (ramp ? CHUNK_W'(k + 1) : '0);
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_done && n < 8);
        chk("frame_done_seen", 64'(frame_done), 64'd1);
    endtask

    task automatic read_word(input int a, output logic [RD_W-1:0] d);
        rd_addr = RA_W'(a);
        step();
        d = rd_data;
    endtask

    initial begin
        int              n;
        int              seq;
        int              lows;
        int              idx_before;
        int              idx_bubble;
        int              prev_idx;
        bit              rdy;
        logic [RD_W-1:0] d;

        step();
        chk_en = 1'b1;
        step();
        step();
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_rd_data",   64'(rd_data),   64'd0);
        RST = 1'b0;
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Ramp frame, overwrite mode.
        mode_or = 1'b0;
        send_frame(CHUNK_W'(1), 1'b1);
        wait_done(n);
        chk("t1_done_cycle", 64'(CHUNKS + n), 64'd33);
        chk("t1_frame_cnt",  64'(frame_cnt),  64'd1);
        read_word(0, d);
        chk("t1_word0",   64'(d), 64'h20);
        read_word(124, d);
        chk("t1_word124", 64'(d), 64'h1);

        // OR versus overwrite on the first chunk slot.
        send_frame(CHUNK_W'(1), 1'b0);
        wait_done(n);
        mode_or = 1'b1;
        send_frame(CHUNK_W'(2), 1'b0);
        wait_done(n);
        read_word(124, d);
        chk("or_word124", 64'(d), 64'h3);
        mode_or = 1'b0;
        send_frame(CHUNK_W'(2), 1'b0);
        wait_done(n);
        read_word(124, d);
        chk("ovw_word124", 64'(d), 64'h2);

        // Continuous valid across a frame boundary.
        seq = 100; lows = 0; idx_before = -1; idx_bubble = -1; prev_idx = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            rdy = in_ready;
            if (!rdy) begin
                lows++;
                idx_before = prev_idx;
                idx_bubble = int'(chunk_idx);
            end
            prev_idx = int'(chunk_idx);
            in_data  = CHUNK_W'(seq);
            step();
            if (rdy) seq++;
        end
        in_valid = 1'b0;
        chk("stream_bubbles",    64'(lows),       64'd1);
        chk("stream_accepted",   64'(seq),        64'd139);
        chk("stream_idx_before", 64'(idx_before), 64'd31);
        chk("stream_idx_bubble", 64'(idx_bubble), 64'd0);
        chk("stream_idx_end",    64'(chunk_idx),  64'd7);
        read_word(0, d);
        chk("stream_word0",   64'(d), 64'h83);
        read_word(124, d);
        chk("stream_word124", 64'(d), 64'h64);

        // Stall holds the partial frame; clear at chunk 17 drops it.
        repeat (20) step();
        chk("stall_idx", 64'(chunk_idx), 64'd7);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = CHUNK_W'(200 + i);
            step();
        end
        chk("pre_clr_idx", 64'(chunk_idx), 64'd17);
        rd_addr = '0;
        clr     = 1'b1;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_idx",    64'(chunk_idx), 64'd0);
        chk("clr_rd_pre", 64'(rd_data),   64'h83);
        chk("clr_cnt",    64'(frame_cnt), 64'd5);
        step();
        chk("clr_rd_post", 64'(rd_data), 64'd0);
        read_word(124, d);
        chk("clr_word124", 64'(d), 64'd0);

        // Reset landing on the commit cycle.
        send_frame(CHUNK_W'(1), 1'b1);
        RST     = 1'b1;
        rd_addr = '0;
        step();
        RST = 1'b0;
        chk("rstc_rd_data",   64'(rd_data),    64'd0);
        chk("rstc_done",      64'(frame_done), 64'd0);
        chk("rstc_frame_cnt", 64'(frame_cnt),  64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstc_no_done", 64'(frame_done), 64'd0);
        end
        read_word(124, d);
        chk("rstc_word124", 64'(d), 64'd0);

        // Counter wrap, plus old/new read around the commit.
        rd_addr = RA_W'(124);
        force dut.frame_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        send_frame(CHUNK_W'(1), 1'b1);
        wait_done(n);
        chk("wrap_cnt",        64'(frame_cnt), 64'd0);
        chk("commit_read_old", 64'(rd_data),   64'd0);
        step();
        chk("done_read_new",   64'(rd_data),   64'h1);

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/edge_accum_v2_0.md
EDGE_ACCUM_V2_0 -- requirements
Module: edge_accum_v2_0

Interface
REQ-001 Parameter CHUNK_W, default 128, SHALL set the input chunk width in bits.
REQ-002 Parameter CHUNKS, default 32, SHALL set the number of chunks per frame (power of two, >=2); FRAME_W = CHUNK_W*CHUNKS.
REQ-003 Parameter RD_W, default 32, SHALL set the read word width (divides FRAME_W); NWORDS = FRAME_W/RD_W, RA_W = clog2(NWORDS).
REQ-004 CLK  input  1  sole clock; all state on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  chunk offered.
REQ-007 in_ready  output  1  block can accept a chunk.
REQ-008 in_data  input  CHUNK_W  edge-mask chunk.
REQ-009 mode_or  input  1  1 = OR new frame into result, 0 = overwrite; sampled in COMMIT.
REQ-010 clr  input  1  synchronous clear of result, frame buffer and chunk index.
REQ-011 chunk_idx  output  clog2(CHUNKS)  index of next chunk to be accepted.
REQ-012 frame_done  output  1  one-cycle pulse, new result visible.
REQ-013 frame_cnt  output  16  committed-frame count, wraps at 65535->0.
REQ-014 rd_addr  input  RA_W  read word address.
REQ-015 rd_data  output  RD_W  registered read word.

Function
REQ-016 States SHALL be FILL and COMMIT; in_ready = (state==FILL) && !clr.
REQ-017 A chunk SHALL be accepted in a cycle with in_valid && in_ready; frame_buf <= (frame_buf << CHUNK_W) | in_data, chunk_idx increments.
REQ-018 Acceptance at chunk_idx==CHUNKS-1 SHALL wrap chunk_idx to 0 and move state to COMMIT.
REQ-019 Chunk accepted k-th (0-based) in a frame SHALL occupy result bits [(CHUNKS-k)*CHUNK_W-1 : (CHUNKS-1-k)*CHUNK_W].
REQ-020 In COMMIT, result SHALL be written with mode_or ? (result | frame_buf) : frame_buf, using the fully assembled frame_buf including the last chunk; state returns to FILL next cycle.
REQ-021 frame_done SHALL be high exactly in the cycle after COMMIT; frame_cnt increments in that same cycle.
REQ-022 in_ready SHALL be low during COMMIT (one bubble per frame); throughput = CHUNKS chunks per CHUNKS+1 cycles.
REQ-023 rd_data SHALL equal result[(a+1)*RD_W-1 : a*RD_W] for a = rd_addr sampled one cycle earlier (latency 1).
REQ-024 A read sampled in the COMMIT cycle SHALL return the pre-commit value; a read sampled in the frame_done cycle returns the new value.
REQ-025 clr SHALL zero result, frame_buf, chunk_idx and force FILL, taking priority over acceptance and COMMIT; no frame_done is produced for a cleared frame; frame_cnt is not altered.
REQ-026 clr SHALL not affect rd_data until the following read sample (rd_data in the clr+1 cycle reflects pre-clear result).
REQ-027 in_valid deassertion mid-frame SHALL hold chunk_idx and frame_buf indefinitely; no timeout.

Reset
REQ-028 On RST: result=0, frame_buf=0, chunk_idx=0, state=FILL, rd_data=0, frame_done=0, frame_cnt=0; RST overrides clr and all inputs.
REQ-029 in_ready SHALL be low while RST is high and high in the first cycle after RST falls (absent clr).
REQ-030 RST mid-frame SHALL discard the partial frame with no commit.

Structure
REQ-031 Package edge_accum_pkg SHALL hold parameter defaults, state encoding (FILL, COMMIT) and the clog2 helper.
REQ-032 Read-word selection SHALL be sub-module edge_accum_rdmux (combinational select of result by address, registered in the parent).

Verification
REQ-033 Defaults, mode_or=0, 32 chunks of value k+1 back-to-back -> frame_done at cycle 33 after first accept; rd_addr=0 -> 0x00000020, rd_addr=124 -> 0x00000001; frame_cnt=1.
REQ-034 Frame A all-zero except chunk0=0x1, then frame B mode_or=1 chunk0=0x2 -> rd_addr=124 returns 0x00000003; repeat with mode_or=0 -> 0x00000002.
REQ-035 in_valid held high across frame boundary -> in_ready low exactly one cycle (COMMIT), no chunk lost, chunk_idx 31->0.
REQ-036 clr asserted with chunk_idx=17 and in_valid=1 -> chunk dropped, chunk_idx=0, result all zero, no frame_done, frame_cnt unchanged.
REQ-037 RST asserted during COMMIT -> result stays 0, frame_done never pulses, rd_data=0 next cycle.
REQ-038 Force frame_cnt=0xFFFF then commit one frame -> frame_cnt=0x0000 with frame_done high.
